alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller, together with the two operands from the decode/register stage.
- Produces the result and a zero flag through a valid/ready handshake.
- Non-shift operations complete in one cycle. Shifts (SLL/SRL/SRA) use an iterative 1-bit-per-cycle shifter to save area.
- Sits between the decode/operand-select logic and the memory/writeback stage.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; taken from SrcB[SHW-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset: asynchronous assert, active-low.
- flush  in  1  synchronous abort of any in-flight operation.
- in_valid  in  1  operand/operation bundle valid.
- in_ready  out  1  unit can accept a bundle this cycle.
- Operation  in  4  ALU operation code, encoded as in alu_pkg.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B / immediate / shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- ALUResult  out  WIDTH  result.
- Zero  out  1  high when ALUResult == 0.

Behaviour:
- Operation encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 0100 XOR.
  - 0101 SLL; 0110 SRL; 0111 SRA.
  - 1000 EQ (A==B); 1001 NE; 1010 LT signed; 1011 GE signed.
  - 1100 PASSB (JAL/LUI), result = SrcB.
  - 1101–1111 are illegal: result 0, single-cycle, no error flag.
- Compare ops (1000–1011) return 1 or 0, zero-extended to WIDTH.
- Arithmetic is modulo 2^WIDTH, with no overflow flag.
- Shift amount = SrcB[SHW-1:0]; upper bits of SrcB are ignored. SRA replicates the captured A[WIDTH-1].
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: out_valid=0, ALUResult=0, Zero=1, in_ready=1. Shift counter and operand registers are 0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Valid accepts bundles back-to-back.
- Accept occurs when in_valid && in_ready at a rising edge:
  - Non-shift op, or shift with amount 0: the result is computed combinationally and registered; next state DONE. out_valid rises the cycle after accept (latency 1).
  - Shift with amount k>0: capture A into the shift register and k into the counter; next state SHIFT.
- SHIFT state: each cycle, shift by 1 in the captured direction and decrement the counter. When the counter reaches 1, the final shift is done and the next state is DONE.
  - Latency from accept to out_valid is k+1 cycles; for example, k=31 gives 32 cycles.
- DONE state: out_valid=1. ALUResult and Zero are held stable while out_valid && !out_ready.
  - On out_ready with a simultaneous accept: load the new bundle (DONE for single-cycle ops, SHIFT for shifts).
  - On out_ready without an accept: go to IDLE, out_valid=0.
- Zero is registered together with ALUResult and always reflects the value currently on ALUResult.
- flush has priority over all other events:
  - Next state IDLE, out_valid=0, counter cleared; ALUResult holds its last value.
  - An in_valid arriving in the same cycle as flush is NOT accepted, even if in_ready=1.
- rst_n low at any time, including mid-SHIFT, asynchronously forces the reset values. Operation resumes on the first rising edge after deassertion.
- Operation and the operands are sampled only at accept; changes to them afterwards have no effect on the in-flight result.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with the codes above;
  - the FSM state enum;
  - helper function is_shift(op).
- Sub-module alu_comb (purely combinational): computes all single-cycle ops (AND/OR/ADD/SUB/XOR/compares/PASSB/illegal) from A, B and op. alu_exec_unit instantiates it and owns the FSM, the iterative shifter and the handshake.

Test Plan:
- Reset, then ADD A=0x0000_0005, B=0xFFFF_FFFB, out_ready=1 -> out_valid one cycle after accept, ALUResult=0, Zero=1. Then SUB 3-5 -> 0xFFFF_FFFE, Zero=0.
- SRA A=0x8000_0000, B=31 -> out_valid exactly 32 cycles after accept, ALUResult=0xFFFF_FFFF, in_ready low throughout SHIFT.
- SLL A=1, B=0x0000_0020 (amount 0) -> latency 1, result 1. SRL A=0xF0, B=4 -> latency 5, result 0x0F.
- Compares: LT A=0xFFFF_FFFF, B=1 -> 1; GE same operands -> 0; NE A=B=7 -> 0 with Zero=1; PASSB B=0x1234_5000 -> 0x1234_5000; op 1110 -> 0.
- Backpressure: three single-cycle ops streamed with out_ready low for 4 cycles -> result held stable; after release, one result per cycle, no loss or duplication.
- Flush at cycle 3 of a 20-cycle SLL -> out_valid stays 0 and in_ready=1 next cycle. Async rst_n pulse mid-SHIFT -> immediate reset values, then a clean ADD completes.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Operation codes, FSM states and helpers for the execute ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_EQ    = 4'b1000,
        ALU_NE    = 4'b1001,
        ALU_LT    = 4'b1010,
        ALU_GE    = 4'b1011,
        ALU_PASSB = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
//  Module   : alu_comb
//  Brief    : Combinational single-cycle ALU operations (logic, add/sub,
//             compares, pass-B). Shift and illegal codes yield zero.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_AND:   o_y = i_a & i_b;
            ALU_OR:    o_y = i_a | i_b;
            ALU_ADD:   o_y = i_a + i_b;
            ALU_SUB:   o_y = i_a - i_b;
            ALU_XOR:   o_y = i_a ^ i_b;
            ALU_EQ:    o_y[0] = (i_a == i_b);
            ALU_NE:    o_y[0] = (i_a != i_b);
            ALU_LT:    o_y[0] = ($signed(i_a) <  $signed(i_b));
            ALU_GE:    o_y[0] = ($signed(i_a) >= $signed(i_b));
            ALU_PASSB: o_y = i_b;
            default:   o_y = '0;
        endcase
    end

endmodule : alu_comb
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Brief    : Execute-stage ALU with valid/ready handshake; single-cycle ops
//             via alu_comb, shifts via an iterative 1-bit-per-cycle shifter.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [SHW-1:0]   r_cnt;
    logic [3:0]       r_op;

    logic [WIDTH-1:0] w_comb;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_shifted;
    logic [SHW-1:0]   w_amt;
    logic             w_accept;
    logic             w_shift_start;
    logic             w_last;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .i_a  (SrcA),
        .i_b  (SrcB),
        .i_op (Operation),
        .o_y  (w_comb)
    );

    assign w_amt         = SrcB[SHW-1:0];
    assign w_accept      = in_valid && in_ready && !flush;
    assign w_shift_start = is_shift(Operation) && (w_amt != '0);
    // A zero-amount shift is just a pass of operand A.
    assign w_imm         = is_shift(Operation) ? SrcA : w_comb;
    assign w_last        = (r_cnt == SHW'(1));

    always_comb begin
        w_shifted = r_sh;
        case (r_op)
            ALU_SLL: w_shifted = {r_sh[WIDTH-2:0], 1'b0};
            ALU_SRL: w_shifted = {1'b0, r_sh[WIDTH-1:1]};
            ALU_SRA: w_shifted = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
            default: w_shifted = r_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        w_next = w_shift_start ? ST_SHIFT : ST_DONE;
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        w_next = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        w_next = ST_DONE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
        out_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh     <= '0;
            r_cnt    <= '0;
            r_op     <= 4'b0000;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_shift_start) begin
                r_sh  <= SrcA;
                r_cnt <= w_amt;
                r_op  <= Operation;
            end else begin
                r_result <= w_imm;
                r_zero   <= (w_imm == '0);
            end
        end else if (r_state == ST_SHIFT) begin
            r_sh  <= w_shifted;
            r_cnt <= r_cnt - SHW'(1);
            if (w_last) begin
                r_result <= w_shifted;
                r_zero   <= (w_shifted == '0);
            end
        end
    end

    assign ALUResult = r_result;
    assign Zero      = r_zero;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Brief    : Directed self-checking bench for alu_exec_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int c_w = 32;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     Operation;
    logic [c_w-1:0] SrcA;
    logic [c_w-1:0] SrcB;
    logic           out_valid;
    logic           out_ready;
    logic [c_w-1:0] ALUResult;
    logic           Zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.WIDTH(c_w)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one bundle from IDLE with out_ready high; measure latency to out_valid.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int  lat;
        logic busy_ok;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        Operation = ~op;
        SrcA      = ~a;
        SrcB      = ~b;
        lat       = 1;
        busy_ok   = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, ALUResult, exp);
        check({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
        if (exp_lat > 1) check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Operation = 4'b0000;
        SrcA      = '0;
        SrcB      = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", 32'(Zero), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        run_op("add",   ALU_ADD,   32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1);
        run_op("sub",   ALU_SUB,   32'd3,         32'd5,         32'hFFFF_FFFE, 1);
        run_op("sra31", ALU_SRA,   32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 32);
        run_op("sll0",  ALU_SLL,   32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1);
        run_op("srl4",  ALU_SRL,   32'h0000_00F0, 32'd4,         32'h0000_000F, 5);
        run_op("sll1",  ALU_SLL,   32'h8000_0001, 32'h0000_0021, 32'h0000_0002, 2);
        run_op("lt",    ALU_LT,    32'hFFFF_FFFF, 32'd1,         32'd1,         1);
        run_op("ge",    ALU_GE,    32'hFFFF_FFFF, 32'd1,         32'd0,         1);
        run_op("ne",    ALU_NE,    32'd7,         32'd7,         32'd0,         1);
        run_op("eq",    ALU_EQ,    32'd7,         32'd7,         32'd1,         1);
        run_op("and",   ALU_AND,   32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
        run_op("passb", ALU_PASSB, 32'h0000_0009, 32'h1234_5000, 32'h1234_5000, 1);
        run_op("ill",   4'b1110,   32'd5,         32'd3,         32'd0,         1);

        // Backpressure: three ops streamed while the sink stalls for 4 cycles.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Operation = ALU_ADD;
        SrcA      = 32'd1;
        SrcB      = 32'd2;
        @(negedge clk);
        Operation = ALU_XOR;
        SrcA      = 32'h0000_00F0;
        SrcB      = 32'h0000_000F;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_hold_res%0d", i), ALUResult, 32'd3);
            check($sformatf("bp_hold_vld%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_rdy%0d", i), 32'(in_ready), 32'd0);
            if (i < 3) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_r2", ALUResult, 32'h0000_00FF);
        Operation = ALU_OR;
        SrcA      = 32'h0000_0100;
        SrcB      = 32'h0000_0001;
        @(negedge clk);
        check("bp_r3", ALUResult, 32'h0000_0101);
        check("bp_r3_vld", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drain", 32'(out_valid), 32'd0);

        // Flush during a 20-cycle SLL.
        in_valid  = 1'b1;
        Operation = ALU_SLL;
        SrcA      = 32'd1;
        SrcB      = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_res_hold", ALUResult, 32'h0000_0101);
        repeat (20) @(negedge clk);
        check("fl_no_late", 32'(out_valid), 32'd0);

        // in_valid coincident with flush while idle must be dropped.
        flush     = 1'b1;
        in_valid  = 1'b1;
        Operation = ALU_PASSB;
        SrcB      = 32'hDEAD_BEEF;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_drop_vld", 32'(out_valid), 32'd0);
        check("fl_drop_res", ALUResult, 32'h0000_0101);

        // Asynchronous reset mid-shift.
        in_valid  = 1'b1;
        Operation = ALU_SRA;
        SrcA      = 32'h8000_0000;
        SrcB      = 32'd10;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_result", ALUResult, 32'd0);
        check("ar_zero", 32'(Zero), 32'd1);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_post", ALU_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1);
        @(negedge clk);
        check("add_post_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire
